// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   - FSM state encoding (RUN / WAIT / ERROR) for the data-memory wait machine
//   - REG_ZERO: architectural zero register, never a hazard source
//   - reg_match(): does a producer destination feed the decode-stage operands
package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_ERROR = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A write to $0 is discarded by the register file, so it can never
    // create a dependency; rt only counts when the decode instruction reads it.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_hazard.sv
// hazard_detect: combinational decode-stage hazard detection.
//   in : id_rs, id_rt, id_uses_rt, id_is_branch   decode operands
//        ex_regdst, ex_regwrite, ex_memread        ID/EX producer
//        mem_regdst, mem_memread                   EX/MEM producer
//   out: load_use_stall  load in EX feeds decode
//        branch_stall    decode branch needs a value not yet forwardable to ID
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic [4:0] ex_regdst,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_regdst,
    input  logic       mem_memread,
    output logic       load_use_stall,
    output logic       branch_stall
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = reg_match(ex_regdst,  id_rs, id_rt, id_uses_rt);
    assign mem_match = reg_match(mem_regdst, id_rs, id_rt, id_uses_rt);

    assign load_use_stall = ex_memread && ex_match;

    // Branches compare in ID, so an ALU result in EX costs one cycle and a
    // load costs two (EX, then MEM). Re-evaluating each cycle yields both.
    assign branch_stall = id_is_branch &&
                          ((ex_regwrite && ex_match) || (mem_memread && mem_match));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush/freeze controller for the 5-stage pipeline.
//   in : clk, reset (async, active-high)
//        decode operands, ID/EX and EX/MEM destination info, mem_ready
//   out: pc_write, ifid_write, idex_write, exmem_write   register enables
//        ifid_flush, idex_bubble, memwb_bubble          zeroing controls
//        mem_timeout                                    sticky wait timeout
//        stall_cycles, flush_count                      saturating counters
// Priority: ERROR > freeze > stall > flush > run.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic [4:0]       ex_regdst,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_regdst,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           load_use_stall;
    logic           branch_stall;
    logic           mem_req;
    logic           freeze;
    logic           stall;

    hazard_detect u_hazard (
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_is_branch   (id_is_branch),
        .ex_regdst      (ex_regdst),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .mem_regdst     (mem_regdst),
        .mem_memread    (mem_memread),
        .load_use_stall (load_use_stall),
        .branch_stall   (branch_stall)
    );

    assign mem_req = mem_memread || mem_memwrite;
    assign stall   = load_use_stall || branch_stall;

    // The cycle mem_ready arrives in WAIT is already a normal RUN cycle.
    assign freeze = (state == ST_ERROR) ||
                    ((state == ST_WAIT) && !mem_ready) ||
                    ((state == ST_RUN) && mem_req && !mem_ready);

    assign mem_timeout = (state == ST_ERROR);

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end else if (branch_taken) begin
            ifid_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WCW'(WAIT_MAX)) begin
                        state <= ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (ifid_flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [6:0] C_RUN    = 7'b1111_000;
    localparam logic [6:0] C_STALL  = 7'b0011_010;
    localparam logic [6:0] C_FLUSH  = 7'b1111_100;
    localparam logic [6:0] C_FREEZE = 7'b0000_001;
    localparam logic [6:0] C_RESET  = 7'b0000_111;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_regdst, mem_regdst;
    logic             id_uses_rt, id_is_branch, branch_taken;
    logic             ex_regwrite, ex_memread, mem_memread, mem_memwrite, mem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_bubble, memwb_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic       to;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .ex_regdst(ex_regdst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_regdst(mem_regdst), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    // Monitor: every cycle with a queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {pc_write, ifid_write, idex_write, exmem_write,
                   ifid_flush, idex_bubble, memwb_bubble};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
            end
            checks++;
            if (mem_timeout !== e.to) begin
                errors++;
                $display("FAIL %s mem_timeout: got %b want %b", e.name, mem_timeout, e.to);
            end
            checks++;
            if (stall_cycles !== e.sc || flush_count !== e.fc) begin
                errors++;
                $display("FAIL %s counters: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                         e.name, stall_cycles, flush_count, e.sc, e.fc);
            end
        end
    end

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0; branch_taken = 0;
        ex_regdst = 0; ex_regwrite = 0; ex_memread = 0;
        mem_regdst = 0; mem_memread = 0; mem_memwrite = 0; mem_ready = 1;
    endtask

    // Inputs for this cycle are already applied; queue the expectation and
    // advance to just after the next rising edge.
    task automatic cyc(input string n, input logic [6:0] c, input logic t,
                       input int s, input int f);
        exp_t e;
        e.name = n; e.ctl = c; e.to = t; e.sc = s[3:0]; e.fc = f[3:0];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        cyc("reset", C_RESET, 0, 0, 0);
        reset = 1'b0;
        cyc("idle", C_RUN, 0, 0, 0);

        // load-use on rs
        ex_memread = 1; ex_regdst = 5; id_rs = 5;
        cyc("load_use", C_STALL, 0, 0, 0);
        clr();
        cyc("after_load_use", C_RUN, 0, 1, 0);

        // $0 never hazards
        ex_memread = 1; ex_regdst = 0; id_rs = 0;
        cyc("reg_zero", C_RUN, 0, 1, 0);

        // rt only counts when read
        clr(); ex_memread = 1; ex_regdst = 7; id_rt = 7;
        cyc("rt_unused", C_RUN, 0, 1, 0);
        id_uses_rt = 1;
        cyc("rt_used", C_STALL, 0, 1, 0);

        // load $8 into beq $8: two stalls, taken ignored while stalled
        clr(); ex_memread = 1; ex_regwrite = 1; ex_regdst = 8;
        id_is_branch = 1; id_rs = 8; branch_taken = 1;
        cyc("ld_br_ex", C_STALL, 0, 2, 0);
        clr(); mem_memread = 1; mem_regdst = 8; mem_ready = 1;
        id_is_branch = 1; id_rs = 8; branch_taken = 1;
        cyc("ld_br_mem", C_STALL, 0, 3, 0);
        clr(); id_is_branch = 1; id_rs = 8; branch_taken = 1;
        cyc("ld_br_flush", C_FLUSH, 0, 4, 0);
        clr();
        cyc("ld_br_after", C_RUN, 0, 4, 1);

        // ALU result into branch: one stall
        ex_regwrite = 1; ex_regdst = 9; id_is_branch = 1; id_rt = 9; id_uses_rt = 1;
        cyc("alu_br_ex", C_STALL, 0, 4, 1);
        clr(); id_is_branch = 1; id_rt = 9; id_uses_rt = 1; branch_taken = 1;
        cyc("alu_br_flush", C_FLUSH, 0, 5, 1);
        clr();
        cyc("alu_br_after", C_RUN, 0, 5, 2);

        // zero-wait memory
        mem_memwrite = 1; mem_ready = 1;
        cyc("zero_wait", C_RUN, 0, 5, 2);

        // 3-cycle memory wait, with a load-use stall overlapping
        clr(); mem_memread = 1; mem_ready = 0;
        cyc("wait1", C_FREEZE, 0, 5, 2);
        ex_memread = 1; ex_regdst = 3; id_rs = 3;
        cyc("wait2_stall", C_FREEZE, 0, 6, 2);
        clr(); mem_memread = 1; mem_ready = 0;
        cyc("wait3", C_FREEZE, 0, 7, 2);
        mem_ready = 1;
        cyc("wait_ready", C_RUN, 0, 8, 2);
        clr();
        cyc("wait_done", C_RUN, 0, 8, 2);

        // timeout: WAIT_MAX wait cycles after the initial freeze cycle
        reset = 1'b1;
        cyc("reset2", C_RESET, 0, 0, 0);
        reset = 1'b0; mem_memread = 1; mem_ready = 0;
        cyc("to_run", C_FREEZE, 0, 0, 0);
        for (int k = 1; k <= WAIT_MAX; k++)
            cyc("to_wait", C_FREEZE, 0, k, 0);
        cyc("to_error", C_FREEZE, 1, WAIT_MAX + 1, 0);
        clr();
        for (int k = WAIT_MAX + 2; k <= 17; k++)
            cyc("to_sticky_sat", C_FREEZE, 1, (k > 15) ? 15 : k, 0);

        // reset in the second WAIT cycle
        reset = 1'b1;
        cyc("reset3", C_RESET, 0, 0, 0);
        reset = 1'b0; mem_memread = 1; mem_ready = 0;
        cyc("mw_run", C_FREEZE, 0, 0, 0);
        cyc("mw_wait1", C_FREEZE, 0, 1, 0);
        reset = 1'b1;
        cyc("mw_reset", C_RESET, 0, 0, 0);
        reset = 1'b0; clr(); mem_ready = 0;
        cyc("mw_after", C_RUN, 0, 0, 0);
        cyc("mw_after2", C_RUN, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
